// File: rtl/temp_sched.sv
// temp_sched: bus-master sequencer that starts a sensor conversion, polls its
// status register at a programmable gap and returns the result to ex.
module temp_sched #(
    parameter logic [31:0] BASE_ADDR = 32'h7004_0000,
    parameter logic [31:0] START_CMD = 32'h0000_0001,
    parameter int unsigned POLL_GAP  = 8,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [4:0]  reg_waddr_i,
    output logic        busy_o,
    output logic        ready_o,
    output logic        err_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_gnt_i
);

    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h0000_0000;
    localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + 32'h0000_0004;
    localparam logic [31:0] ADDR_DATA   = BASE_ADDR + 32'h0000_0008;
    localparam logic [7:0]  GAP_LAST    = 8'(POLL_GAP - 32'd1);
    localparam logic [15:0] TIMEOUT_V   = 16'(TIMEOUT);
    localparam bit          GAP_ZERO    = (POLL_GAP == 32'd0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_POLL  = 3'd3,
        S_READ  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] poll_q, poll_d, poll_inc;
    logic        err_q, err_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] res_q, res_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    // Next-state, counters and captured result; flush overrides everything outside IDLE.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        poll_d   = poll_q;
        err_d    = err_q;
        waddr_d  = waddr_q;
        res_d    = res_q;
        poll_inc = (poll_q != TIMEOUT_V) ? (poll_q + 16'd1) : poll_q;
        if (flush_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        waddr_d = reg_waddr_i;
                        poll_d  = 16'd0;
                        gap_d   = 8'd0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (mem_gnt_i) begin
                        gap_d   = 8'd0;
                        state_d = GAP_ZERO ? S_POLL : S_WAIT;
                    end else begin
                        state_d = S_START;
                    end
                end
                S_WAIT: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = 8'd0;
                        state_d = S_POLL;
                    end else begin
                        gap_d   = gap_q + 8'd1;
                        state_d = S_WAIT;
                    end
                end
                S_POLL: begin
                    if (mem_gnt_i) begin
                        poll_d = poll_inc;
                        gap_d  = 8'd0;
                        if (!mem_rdata_i[0]) begin
                            state_d = S_READ;
                        end else if (poll_inc == TIMEOUT_V) begin
                            err_d   = 1'b1;
                            res_d   = 32'd0;
                            state_d = S_DONE;
                        end else begin
                            state_d = GAP_ZERO ? S_POLL : S_WAIT;
                        end
                    end else begin
                        state_d = S_POLL;
                    end
                end
                S_READ: begin
                    if (mem_gnt_i) begin
                        res_d   = mem_rdata_i;
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Bus and status outputs decoded from the next state so they leave a flop.
    always_comb begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = 32'd0;
        wdata_d = 32'd0;
        case (state_d)
            S_START: begin
                req_d   = 1'b1;
                we_d    = 1'b1;
                addr_d  = ADDR_CTRL;
                wdata_d = START_CMD;
            end
            S_POLL: begin
                req_d  = 1'b1;
                addr_d = ADDR_STATUS;
            end
            S_READ: begin
                req_d  = 1'b1;
                addr_d = ADDR_DATA;
            end
            default: begin
                req_d   = 1'b0;
                we_d    = 1'b0;
                addr_d  = 32'd0;
                wdata_d = 32'd0;
            end
        endcase
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gap_q   <= 8'd0;
            poll_q  <= 16'd0;
            err_q   <= 1'b0;
            waddr_q <= 5'd0;
            res_q   <= 32'd0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            poll_q  <= poll_d;
            err_q   <= err_d;
            waddr_q <= waddr_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy_o      = busy_q;
    assign ready_o     = ready_q;
    assign err_o       = err_q;
    assign reg_waddr_o = waddr_q;
    assign reg_wdata_o = res_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_temp_sched.sv
// Bench for temp_sched: two instances (gap 0 / gap 3 with timeout 4) share a
// sensor model; bus transfers and results are checked against scoreboard queues.
module tb_temp_sched;

    localparam logic [31:0] A_STATUS = 32'h7004_0000;
    localparam logic [31:0] A_CTRL   = 32'h7004_0004;
    localparam logic [31:0] A_DATA   = 32'h7004_0008;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic        err;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        int          lat;
    } res_t;

    typedef struct {
        logic        sel;
        logic [4:0]  waddr;
        logic [31:0] data;
        int          busy_polls;
        int          stall_w;
        int          stall_r;
        logic        exp_err;
        int          exp_polls;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     = 1'b0;
    logic       start_s = 1'b0;
    logic       flush_s = 1'b0;
    logic       sel     = 1'b0;
    logic [4:0] waddr_s = 5'd0;

    logic        start_w [2];
    logic        flush_w [2];
    logic        gnt_w   [2];
    logic        busy_w  [2];
    logic        ready_w [2];
    logic        err_w   [2];
    logic        req_w   [2];
    logic        we_w    [2];
    logic [4:0]  waddr_w [2];
    logic [31:0] rdata_w [2];
    logic [31:0] res_w   [2];
    logic [31:0] addr_w  [2];
    logic [31:0] mwd_w   [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    int reqs    = 0;

    int polls_seen = 0, stw_cnt = 0, str_cnt = 0;
    int polls_base = 0, stw_base = 0, str_base = 0;
    int busy_polls = 0, stall_w = 0, stall_r = 0;
    logic [31:0] sensor_data = 32'd0;

    bus_t busq[$];
    res_t resq[$];
    vec_t vecs[8];

    logic        m_req, m_we, m_gnt, m_busy, m_ready, m_err;
    logic [31:0] m_addr, m_wdata, m_res, m_rdata;
    logic [4:0]  m_waddr;

    assign m_req   = req_w[sel];
    assign m_we    = we_w[sel];
    assign m_addr  = addr_w[sel];
    assign m_wdata = mwd_w[sel];
    assign m_busy  = busy_w[sel];
    assign m_ready = ready_w[sel];
    assign m_err   = err_w[sel];
    assign m_res   = res_w[sel];
    assign m_waddr = waddr_w[sel];

    assign m_gnt = m_req && ((m_addr == A_CTRL) ? ((stw_cnt - stw_base) >= stall_w) :
                             (m_addr == A_DATA) ? ((str_cnt - str_base) >= stall_r) : 1'b1);
    assign m_rdata = (m_addr == A_STATUS) ? {31'd0, ((polls_seen - polls_base) < busy_polls)} :
                     (m_addr == A_DATA) ? sensor_data : 32'd0;

    assign start_w[0] = start_s && !sel;
    assign start_w[1] = start_s && sel;
    assign flush_w[0] = flush_s && !sel;
    assign flush_w[1] = flush_s && sel;
    assign gnt_w[0]   = m_gnt && !sel;
    assign gnt_w[1]   = m_gnt && sel;
    assign rdata_w[0] = sel ? 32'd0 : m_rdata;
    assign rdata_w[1] = sel ? m_rdata : 32'd0;

    temp_sched #(.POLL_GAP(0), .TIMEOUT(1000)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_w[0]), .flush_i(flush_w[0]),
        .reg_waddr_i(waddr_s), .busy_o(busy_w[0]), .ready_o(ready_w[0]), .err_o(err_w[0]),
        .reg_waddr_o(waddr_w[0]), .reg_wdata_o(res_w[0]), .mem_req_o(req_w[0]),
        .mem_we_o(we_w[0]), .mem_addr_o(addr_w[0]), .mem_wdata_o(mwd_w[0]),
        .mem_rdata_i(rdata_w[0]), .mem_gnt_i(gnt_w[0])
    );

    temp_sched #(.POLL_GAP(3), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_w[1]), .flush_i(flush_w[1]),
        .reg_waddr_i(waddr_s), .busy_o(busy_w[1]), .ready_o(ready_w[1]), .err_o(err_w[1]),
        .reg_waddr_o(waddr_w[1]), .reg_wdata_o(res_w[1]), .mem_req_o(req_w[1]),
        .mem_we_o(we_w[1]), .mem_addr_o(addr_w[1]), .mem_wdata_o(mwd_w[1]),
        .mem_rdata_i(rdata_w[1]), .mem_gnt_i(gnt_w[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sensor model bookkeeping: stall counters and poll count seen by the DUT.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_req && !m_gnt && m_addr == A_CTRL) stw_cnt <= stw_cnt + 1;
        if (m_req && !m_gnt && m_addr == A_DATA) str_cnt <= str_cnt + 1;
        if (m_req && m_gnt && m_addr == A_STATUS) polls_seen <= polls_seen + 1;
    end

    logic        prev_stall = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;

    // Monitor: compares bus transfers, stall stability and results with the queues.
    always @(negedge clk) begin
        bus_t b;
        res_t r;
        if (prev_stall && m_req) begin
            check("stall_addr", 64'(m_addr), 64'(prev_addr));
            check("stall_we", 64'(m_we), 64'(prev_we));
            check("stall_wdata", 64'(m_wdata), 64'(prev_wdata));
        end
        prev_stall = m_req && !m_gnt;
        prev_addr  = m_addr;
        prev_we    = m_we;
        prev_wdata = m_wdata;
        if (m_req && m_gnt) begin
            check("bus_expected", 64'(busq.size() != 0), 64'd1);
            if (busq.size() != 0) begin
                b = busq.pop_front();
                check("bus_we", 64'(m_we), 64'(b.we));
                check("bus_addr", 64'(m_addr), 64'(b.addr));
                check("bus_wdata", 64'(m_wdata), 64'(b.wdata));
            end
        end
        if (m_ready === 1'b1) begin
            check("ready_expected", 64'(resq.size() != 0), 64'd1);
            if (resq.size() != 0) begin
                r = resq.pop_front();
                check("res_err", 64'(m_err), 64'(r.err));
                check("res_waddr", 64'(m_waddr), 64'(r.waddr));
                check("res_wdata", 64'(m_res), 64'(r.wdata));
                check("latency", 64'(cyc - t0), 64'(r.lat));
            end
        end
        if (rst) begin
            check("other_dut_quiet", 64'({req_w[~sel], ready_w[~sel]}), 64'd0);
        end
    end

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus_t b;
        b.we = we;
        b.addr = addr;
        b.wdata = wdata;
        busq.push_back(b);
    endtask

    task automatic push_conv(input logic [4:0] w, input int polls, input logic e,
                             input logic [31:0] d, input int lat);
        res_t r;
        push_bus(1'b1, A_CTRL, 32'h0000_0001);
        for (int k = 0; k < polls; k++) push_bus(1'b0, A_STATUS, 32'd0);
        if (!e) push_bus(1'b0, A_DATA, 32'd0);
        r.err = e;
        r.waddr = w;
        r.wdata = e ? 32'd0 : d;
        r.lat = lat;
        resq.push_back(r);
    endtask

    task automatic setup_model(input logic s, input logic [31:0] d, input int bp,
                               input int sw, input int sr);
        sel = s;
        sensor_data = d;
        busy_polls = bp;
        stall_w = sw;
        stall_r = sr;
        polls_base = polls_seen;
        stw_base = stw_cnt;
        str_base = str_cnt;
    endtask

    task automatic drive_start(input logic [4:0] w);
        @(negedge clk);
        start_s = 1'b1;
        waddr_s = w;
        t0 = cyc;
        @(negedge clk);
        start_s = 1'b0;
        waddr_s = ~w;
    endtask

    task automatic wait_results(input int left);
        int c;
        c = 0;
        while (resq.size() > left && c < 400) begin
            @(posedge clk);
            c++;
        end
        check("result_arrived", 64'(resq.size()), 64'(left));
        if (resq.size() > left) resq.delete();
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        setup_model(v.sel, v.data, v.busy_polls, v.stall_w, v.stall_r);
        push_conv(v.waddr, v.exp_polls, v.exp_err, v.data, v.exp_lat);
        drive_start(v.waddr);
        check("busy_rise", 64'(m_busy), 64'd1);
        wait_results(0);
        @(negedge clk);
        check("busy_fall", 64'(m_busy), 64'd0);
        check("bus_drained", 64'(busq.size()), 64'd0);
    endtask

    initial begin
        //            sel   waddr  data            busy sw sr err  polls lat
        vecs[0] = '{1'b0, 5'd10, 32'h0000_0123,   0,  0, 0, 1'b0, 1,  4};
        vecs[1] = '{1'b0, 5'd31, 32'hDEAD_BEEF,   2,  0, 0, 1'b0, 3,  6};
        vecs[2] = '{1'b0, 5'd7,  32'hA5A5_0F0F,   0,  5, 3, 1'b0, 1,  12};
        vecs[3] = '{1'b0, 5'd0,  32'hFFFF_FFFF,   5,  0, 0, 1'b0, 6,  9};
        vecs[4] = '{1'b1, 5'd3,  32'h0000_0055,   2,  0, 0, 1'b0, 3,  15};
        vecs[5] = '{1'b1, 5'd20, 32'h0000_0077,   100, 0, 0, 1'b1, 4,  18};
        vecs[6] = '{1'b1, 5'd21, 32'h1357_9BDF,   3,  0, 0, 1'b0, 4,  19};
        vecs[7] = '{1'b1, 5'd1,  32'h8000_0001,   0,  0, 0, 1'b0, 1,  7};

        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", 64'(busy_w[i]), 64'd0);
            check("rst_ready", 64'(ready_w[i]), 64'd0);
            check("rst_err", 64'(err_w[i]), 64'd0);
            check("rst_waddr", 64'(waddr_w[i]), 64'd0);
            check("rst_wdata", 64'(res_w[i]), 64'd0);
            check("rst_req", 64'(req_w[i]), 64'd0);
            check("rst_we", 64'(we_w[i]), 64'd0);
            check("rst_addr", 64'(addr_w[i]), 64'd0);
            check("rst_mwdata", 64'(mwd_w[i]), 64'd0);
        end
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (req_w[0] !== 1'b0 || req_w[1] !== 1'b0) reqs++;
        end
        check("idle_no_req", 64'(reqs), 64'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back: second start in the first IDLE cycle after DONE.
        @(negedge clk);
        setup_model(1'b0, 32'h0BAD_F00D, 0, 0, 0);
        push_conv(5'd17, 1, 1'b0, 32'h0BAD_F00D, 4);
        push_conv(5'd18, 1, 1'b0, 32'h0BAD_F00D, 4);
        drive_start(5'd17);
        wait_results(1);
        drive_start(5'd18);
        wait_results(0);
        @(negedge clk);
        check("b2b_busy_fall", 64'(m_busy), 64'd0);
        check("b2b_bus_drained", 64'(busq.size()), 64'd0);

        // Flush together with start in IDLE: request ignored.
        @(negedge clk);
        start_s = 1'b1;
        flush_s = 1'b1;
        waddr_s = 5'd9;
        @(negedge clk);
        start_s = 1'b0;
        flush_s = 1'b0;
        check("flush_start_busy", 64'(m_busy), 64'd0);
        repeat (10) @(negedge clk);
        check("flush_start_req", 64'(m_req), 64'd0);

        // Flush while in WAIT on the gapped instance.
        @(negedge clk);
        setup_model(1'b1, 32'h0000_0042, 0, 0, 0);
        push_bus(1'b1, A_CTRL, 32'h0000_0001);
        drive_start(5'd4);
        @(negedge clk);
        flush_s = 1'b1;
        @(negedge clk);
        flush_s = 1'b0;
        check("flush_wait_busy", 64'(m_busy), 64'd0);
        check("flush_wait_req", 64'(m_req), 64'd0);
        repeat (20) @(negedge clk);
        check("flush_wait_bus", 64'(busq.size()), 64'd0);

        // start_i while busy is ignored; exactly one result appears.
        @(negedge clk);
        setup_model(1'b0, 32'h0000_4321, 5, 0, 0);
        push_conv(5'd12, 6, 1'b0, 32'h0000_4321, 9);
        drive_start(5'd12);
        @(negedge clk);
        @(negedge clk);
        start_s = 1'b1;
        waddr_s = 5'd1;
        @(negedge clk);
        start_s = 1'b0;
        wait_results(0);
        repeat (20) @(negedge clk);
        check("busy_start_bus", 64'(busq.size()), 64'd0);

        // Reset asserted during POLL aborts with no ready.
        @(negedge clk);
        setup_model(1'b0, 32'h0000_0099, 50, 0, 0);
        push_bus(1'b1, A_CTRL, 32'h0000_0001);
        push_bus(1'b0, A_STATUS, 32'd0);
        push_bus(1'b0, A_STATUS, 32'd0);
        drive_start(5'd2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_poll_busy", 64'(m_busy), 64'd0);
        check("rst_poll_req", 64'(m_req), 64'd0);
        check("rst_poll_ready", 64'(m_ready), 64'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_poll_bus", 64'(busq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/temp_sched.md
# temp_sched

Bus-master sequencer for the on-chip temperature sensor peripheral. It sits between the execute stage and the sensor's memory-mapped registers. On a request from ex it:
- writes the conversion-start command;
- polls the status register at a programmable interval until the sensor reports done or a timeout expires;
- reads the result register and hands the value and its destination register address back to ex.

## Interface
Parameters:
- BASE_ADDR, 32'h7004_0000, sensor register base. STATUS = BASE+0x0 (bit0 = 1 busy, 0 done); CTRL = BASE+0x4; DATA = BASE+0x8.
- START_CMD, 32'h0000_0001, value written to CTRL to start a conversion.
- POLL_GAP, 8, idle cycles inserted before every STATUS poll (0 = back-to-back polls).
- TIMEOUT, 1000, maximum number of STATUS polls per conversion (range 1..65535).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-low.
- start_i  in  1  conversion request; sampled only in IDLE.
- flush_i  in  1  abort from pipeline control; returns to IDLE.
- reg_waddr_i  in  5  destination register, captured with start_i.
- busy_o  out  1  high in every state except IDLE.
- ready_o  out  1  one-cycle result strobe.
- err_o  out  1  qualifies ready_o: 1 = timeout.
- reg_waddr_o  out  5  captured destination register.
- reg_wdata_o  out  32  sensor result (0 on timeout).
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  bus address.
- mem_wdata_o  out  32  write data.
- mem_rdata_i  in  32  read data, valid in the cycle mem_req_o && mem_gnt_i.
- mem_gnt_i  in  1  grant; a transfer completes in any cycle where req && gnt.

## Operation
- States: IDLE, START, WAIT, POLL, READ, DONE.
- IDLE:
  - If start_i=1: capture reg_waddr_i, clear the poll counter, go to START.
  - Otherwise stay.
- START: drive req=1, we=1, addr=CTRL, wdata=START_CMD. On gnt, go to WAIT (or to POLL if POLL_GAP=0).
- WAIT: no request. The gap counter counts POLL_GAP cycles, then goes to POLL.
- POLL: drive req=1, we=0, addr=STATUS. On gnt, increment the poll counter, then:
  - rdata[0]=0: go to READ.
  - Else if poll counter == TIMEOUT: set err, go to DONE.
  - Else: go to WAIT (or stay in POLL if POLL_GAP=0).
- READ: drive req=1, we=0, addr=DATA. On gnt, latch rdata into reg_wdata_o, clear err, go to DONE.
- DONE:
  - ready_o=1 for exactly this one cycle; err_o, reg_waddr_o and reg_wdata_o are valid alongside it.
  - Next state IDLE.
- Bus rules:
  - Without gnt, req, we, addr and wdata are held stable.
  - mem_req_o=0 in IDLE, WAIT and DONE.
  - mem_wdata_o = 0 whenever we=0.
- flush_i=1 in any non-IDLE state: next state IDLE.
  - No ready_o.
  - An ungranted request is dropped.
  - flush_i in IDLE has no effect.
  - flush_i together with start_i in IDLE: flush wins, request ignored.
- start_i while busy is ignored (not queued).
- Counters:
  - Gap counter is 8-bit.
  - Poll counter is 16-bit and saturates at TIMEOUT; it never wraps.
- reg_waddr_o and reg_wdata_o hold their last value until the next capture.

## Timing
- Reset (rst=0 at an edge): state IDLE, busy_o=0, ready_o=0, err_o=0, reg_waddr_o=0, reg_wdata_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0. Reset mid-conversion aborts immediately, with no ready_o.
- Outputs are registered or decoded from registered state; there is no combinational path from mem_rdata_i to ready_o.
- Example: start_i sampled at edge 0, POLL_GAP=0, gnt always 1, first poll returns done:
  - START during cycle 1;
  - POLL during cycle 2;
  - READ during cycle 3;
  - ready_o during cycle 4.
  This is the minimum latency: 4 cycles.
- General latency with gnt always 1 and done on poll N: 4 + (N-1) + N·POLL_GAP cycles.
- Each gnt stall adds one cycle to the state that is stalled.
- busy_o rises the cycle after start_i is sampled and falls the cycle after DONE.
- Back-to-back: a start_i asserted in the first IDLE cycle after DONE is accepted.

## Test plan
- Reset then idle: rst=0 for 2 cycles → all outputs 0. Release with start_i=0 → no mem_req_o for 20 cycles.
- Single conversion: POLL_GAP=0, gnt=1, STATUS returns 0 on the first poll, DATA=32'h0000_0123, reg_waddr_i=5'd10 → bus sequence write 0x7004_0004=1, read 0x7004_0000, read 0x7004_0008. ready_o in cycle 4 with reg_wdata_o=0x123, reg_waddr_o=10, err_o=0.
- Polling with gap: POLL_GAP=3, STATUS busy for 2 polls then done → exactly 3 STATUS reads, each preceded by 3 request-free cycles. ready_o at cycle 4+2+9=15.
- Timeout: TIMEOUT=4, STATUS stuck at 1 → exactly 4 polls, then ready_o with err_o=1 and reg_wdata_o=0. No DATA read occurs.
- Grant stall: gnt=0 for 5 cycles during START and 3 cycles during READ → addr, we and wdata stable throughout each stall; latency grows by 8 cycles.
- Abort: flush_i in WAIT, and separately rst=0 during POLL → IDLE next cycle, busy_o=0, no ready_o. start_i pulsed while busy → ignored, with exactly one conversion observed.
